fft_input_buffer: RTL and testbench

Ping-pong input buffer placed directly upstream of the sample counter and butterfly stages. It collects a stream of complex samples into one of two NUM-entry banks. It then replays each completed frame in bit-reversed order on a valid/ready output, so the counter and radix-2 butterflies downstream receive exactly NUM valid beats per frame. Writing one bank while reading the other sustains one sample per clock.

---
 rtl/fft_input_buffer.sv | 123 ++++++++++++
 tb/tb_fft_input_buffer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_buffer.sv
// Ping-pong input buffer: fills one bank in natural order while replaying the
// other bank in bit-reversed order on a valid/ready output stream.
module fft_input_buffer #(
  parameter int unsigned NUM = 16,
  parameter int unsigned DW  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_valid,
  input  logic [DW-1:0]           din_re,
  input  logic [DW-1:0]           din_im,
  output logic                    din_ready,
  output logic                    dout_valid,
  output logic [DW-1:0]           dout_re,
  output logic [DW-1:0]           dout_im,
  output logic [$clog2(NUM)-1:0]  dout_idx,
  output logic                    dout_last,
  input  logic                    dout_ready
);

  localparam int unsigned AW = $clog2(NUM);
  localparam int unsigned SW = 2 * DW;

  // Sample storage, {re, im} per entry; contents are intentionally not reset.
  logic [SW-1:0] mem [2][NUM];

  logic [1:0]    full;
  logic          wr_bank;
  logic [AW-1:0] wr_cnt;
  logic          rd_bank;
  logic [AW-1:0] rd_cnt;

  logic          wr_en;
  logic          wr_last;
  logic          rd_load;
  logic          rd_last;
  logic [AW-1:0] rd_addr;
  logic [SW-1:0] rd_word;
  logic [1:0]    full_nxt;

  // Input is accepted whenever the bank being written is not holding a frame.
  assign din_ready = ~full[wr_bank];

  // Handshake decode, bit-reversed read address and full-flag update.
  always_comb begin
    wr_en    = din_valid & din_ready;
    wr_last  = (wr_cnt == AW'(NUM - 1));
    rd_load  = full[rd_bank] & (~dout_valid | dout_ready);
    rd_last  = (rd_cnt == AW'(NUM - 1));
    rd_addr  = '0;
    for (int i = 0; i < int'(AW); i++) begin
      rd_addr[i] = rd_cnt[int'(AW) - 1 - i];
    end
    rd_word  = mem[rd_bank][rd_addr];
    full_nxt = full;
    // A set needs the bit clear and a clear needs it set, so they never collide.
    if (wr_en && wr_last) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (rd_load && rd_last) begin
      full_nxt[rd_bank] = 1'b0;
    end
  end

  // Bank write port: sample lands at the accepting edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_cnt] <= {din_re, din_im};
    end
  end

  // Write-side pointer and bank selection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (wr_en) begin
      if (wr_last) begin
        wr_bank <= ~wr_bank;
        wr_cnt  <= '0;
      end else begin
        wr_cnt  <= wr_cnt + AW'(1);
      end
    end
  end

  // Bank occupancy flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= '0;
    end else begin
      full <= full_nxt;
    end
  end

  // Read-side pointer and registered output beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_bank    <= 1'b0;
      rd_cnt     <= '0;
      dout_valid <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
      dout_idx   <= '0;
      dout_last  <= 1'b0;
    end else if (rd_load) begin
      dout_valid <= 1'b1;
      dout_re    <= rd_word[SW-1:DW];
      dout_im    <= rd_word[DW-1:0];
      dout_idx   <= rd_cnt;
      dout_last  <= rd_last;
      if (rd_last) begin
        rd_bank  <= ~rd_bank;
        rd_cnt   <= '0;
      end else begin
        rd_cnt   <= rd_cnt + AW'(1);
      end
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Self-checking bench for fft_input_buffer: frame-level reference model built
// from queues, bit reversal by arithmetic, directed steps with random data.
module tb_fft_input_buffer;

  localparam int unsigned NUM = 16;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din_re = '0;
  logic [DW-1:0] din_im = '0;
  logic          din_ready;
  logic          dout_valid;
  logic [DW-1:0] dout_re;
  logic [DW-1:0] dout_im;
  logic [AW-1:0] dout_idx;
  logic          dout_last;
  logic          dout_ready = 1'b0;

  fft_input_buffer #(.NUM(NUM), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_re     (din_re),
    .din_im     (din_im),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout_re    (dout_re),
    .dout_im    (dout_im),
    .dout_idx   (dout_idx),
    .dout_last  (dout_last),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [AW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [2*DW-1:0] in_buf[$];
  int checks    = 0;
  int errors    = 0;
  int frames_in = 0;
  int beats_out = 0;
  bit stream_mon = 1'b0;
  bit seen_valid = 1'b0;
  int gaps       = 0;

  function automatic int brev(input int x);
    int r = 0;
    int v = x;
    for (int b = 0; b < int'(AW); b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Collect accepted samples; each completed frame becomes NUM expected beats.
  task automatic push_model(input logic [2*DW-1:0] s);
    beat_t b;
    logic [2*DW-1:0] w;
    in_buf.push_back(s);
    if (in_buf.size() == int'(NUM)) begin
      for (int i = 0; i < int'(NUM); i++) begin
        w      = in_buf[brev(i)];
        b.re   = w[2*DW-1:DW];
        b.im   = w[DW-1:0];
        b.idx  = AW'(i);
        b.last = (i == int'(NUM) - 1);
        exp_q.push_back(b);
      end
      in_buf.delete();
      frames_in++;
    end
  endtask

  // One clock: check outputs at the falling edge, update model, advance.
  task automatic tick();
    int loaded;
    bit exp_rdy;
    @(negedge clk);
    loaded  = beats_out + (dout_valid ? 1 : 0);
    exp_rdy = ((frames_in - loaded / int'(NUM)) < 2);
    chk("din_ready", {31'd0, din_ready}, {31'd0, exp_rdy});
    if (stream_mon) begin
      if (dout_valid) seen_valid = 1'b1;
      else if (seen_valid && exp_q.size() > 0) gaps++;
    end
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", {31'd0, dout_valid}, 32'd0);
      end else begin
        chk("dout_re",   {16'd0, dout_re},   {16'd0, exp_q[0].re});
        chk("dout_im",   {16'd0, dout_im},   {16'd0, exp_q[0].im});
        chk("dout_idx",  {28'd0, dout_idx},  {28'd0, exp_q[0].idx});
        chk("dout_last", {31'd0, dout_last}, {31'd0, exp_q[0].last});
        if (dout_ready) begin
          void'(exp_q.pop_front());
          beats_out++;
        end
      end
    end
    if (din_valid && exp_rdy) push_model({din_re, din_im});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    while (exp_q.size() > 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic rand_in();
    din_re = DW'($urandom);
    din_im = DW'($urandom);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_re",    {16'd0, dout_re},    32'd0);
    chk("rst_ready", {31'd0, din_ready},  32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single frame re=k, im=-k with fill-to-output latency check
    dout_ready = 1'b1;
    for (int k = 0; k < int'(NUM); k++) begin
      din_valid = 1'b1;
      din_re    = DW'(k);
      din_im    = DW'(-k);
      tick();
    end
    din_valid = 1'b0;
    chk("lat_edge_e", {31'd0, dout_valid}, 32'd0);
    tick();
    chk("lat_edge_e1", {31'd0, dout_valid}, 32'd1);
    chk("first_re", {16'd0, dout_re}, 32'd0);
    drain();

    // Continuous streaming: four back-to-back frames
    stream_mon = 1'b1;
    seen_valid = 1'b0;
    gaps       = 0;
    dout_ready = 1'b1;
    for (int k = 0; k < 4 * int'(NUM); k++) begin
      din_valid = 1'b1;
      rand_in();
      tick();
    end
    drain();
    stream_mon = 1'b0;
    chk("stream_gaps", 32'(gaps), 32'd0);

    // Random backpressure and input bubbles
    for (int k = 0; k < 300; k++) begin
      din_valid  = ($urandom % 4) != 0;
      dout_ready = $urandom % 2;
      rand_in();
      tick();
    end
    drain();

    // Asynchronous reset in the middle of activity
    for (int k = 0; k < 23; k++) begin
      din_valid  = 1'b1;
      dout_ready = $urandom % 2;
      rand_in();
      tick();
    end
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, dout_valid}, 32'd0);
    chk("arst_re",    {16'd0, dout_re},    32'd0);
    chk("arst_im",    {16'd0, dout_im},    32'd0);
    chk("arst_idx",   {28'd0, dout_idx},   32'd0);
    chk("arst_last",  {31'd0, dout_last},  32'd0);
    chk("arst_ready", {31'd0, din_ready},  32'd1);
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    exp_q.delete();
    in_buf.delete();
    frames_in = 0;
    beats_out = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Both banks full: 32 samples with output stalled, 33rd refused
    dout_ready = 1'b0;
    for (int k = 0; k < 2 * int'(NUM); k++) begin
      din_valid = 1'b1;
      rand_in();
      tick();
    end
    chk("full_ready_low", {31'd0, din_ready}, 32'd0);
    din_re = 16'hDEAD;
    din_im = 16'hBEEF;
    repeat (4) tick();
    din_valid = 1'b0;
    chk("full_frames", 32'(frames_in), 32'd2);
    drain();

    // Partial frame: 5 samples sit silently, 11 more complete the frame
    dout_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din_valid = 1'b1;
      rand_in();
      tick();
    end
    din_valid = 1'b0;
    repeat (10) tick();
    chk("partial_idle", {31'd0, dout_valid}, 32'd0);
    for (int k = 0; k < 11; k++) begin
      din_valid = 1'b1;
      rand_in();
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
